dec_rr_arbiter: RTL and testbench

Round-robin arbiter that shares one enabled 2-to-4 decoder between four requesters. It samples a 4-bit request vector and picks one winner. It then drives the decoder's enable and select lines (E, S1, S0) and the matching one-hot grant, and holds the grant until the winner releases it. It sits directly in front of the existing struct, equation and behavioural 2-to-4 decoders. Any of them can be wired to E/S1/S0, and its O3..O0 outputs must equal gnt.

---
 rtl/dec_rr_arbiter.sv | 126 ++++++++++++
 tb/tb_dec_rr_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/dec_rr_arbiter.sv
// dec_rr_arbiter: round-robin arbiter sharing one enabled 2-to-4 decoder
// between four requesters. Drives E/S1/S0 for the decoder plus the matching
// one-hot grant, and holds the grant until the owner releases it.
// Optional feature: define ARB_TIMEOUT_EN to build the hold counter that
// forcibly revokes a grant after MAX_HOLD cycles. Without it, timeout stays 0.
module dec_rr_arbiter #(
    parameter int MAX_HOLD = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] req,
    input  logic       done,
    output logic       E,
    output logic       S1,
    output logic       S0,
    output logic [3:0] gnt,
    output logic       busy,
    output logic       timeout
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t     state;
    logic [1:0] ptr;
    logic       found;
    logic [1:0] winner;
    logic [1:0] idx;
    logic       owner_req;
    logic       rel_cond;

`ifdef ARB_TIMEOUT_EN
    logic [7:0] hold_cnt;
    logic       hold_expired;
    logic       forced;

    // Hold limit reached: the grant has already been high MAX_HOLD cycles
    // once this edge completes, so the release happens on this edge.
    always_comb begin
        hold_expired = (hold_cnt == 8'(MAX_HOLD - 1));
        forced       = hold_expired && !done && owner_req;
    end
`endif

    // Search the request vector starting at ptr and wrapping modulo 4;
    // the first set bit wins.
    always_comb begin
        found  = 1'b0;
        winner = ptr;
        idx    = ptr;
        for (int k = 0; k < 4; k++) begin
            idx = ptr + 2'(k);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end

    // The owner is identified by the registered select lines; the grant is
    // released on done, on the owner dropping its request, or on expiry.
    always_comb begin
        owner_req = req[{S1, S0}];
`ifdef ARB_TIMEOUT_EN
        rel_cond  = done || !owner_req || hold_expired;
`else
        rel_cond  = done || !owner_req;
`endif
    end

    // Arbitration state machine with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            ptr      <= 2'd0;
            E        <= 1'b0;
            S1       <= 1'b0;
            S0       <= 1'b0;
            gnt      <= 4'b0000;
            busy     <= 1'b0;
            timeout  <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt <= 8'd0;
`endif
        end else begin
            timeout <= 1'b0;
            case (state)
                IDLE: begin
                    if (found) begin
                        S1       <= winner[1];
                        S0       <= winner[0];
                        E        <= 1'b1;
                        busy     <= 1'b1;
                        gnt      <= 4'b0001 << winner;
                        ptr      <= winner + 2'd1;
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= 8'd0;
`endif
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (rel_cond) begin
                        E     <= 1'b0;
                        busy  <= 1'b0;
                        gnt   <= 4'b0000;
                        state <= IDLE;
`ifdef ARB_TIMEOUT_EN
                        timeout <= forced;
`endif
                    end else begin
`ifdef ARB_TIMEOUT_EN
                        hold_cnt <= hold_cnt + 8'd1;
`endif
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dec_rr_arbiter.sv
// Testbench for dec_rr_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all checked every cycle against a
// behavioural owner/pointer model. Build with ARB_TIMEOUT_EN to cover the
// hold timeout (MAX_HOLD is 4 here).
module tb_dec_rr_arbiter;

    localparam int TB_MAX_HOLD = 4;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic       done;
    logic       E;
    logic       S1;
    logic       S0;
    logic [3:0] gnt;
    logic       busy;
    logic       timeout;

    int checks;
    int errors;
    bit chk_en;

    // Behavioural model: which requester owns the decoder (-1 = nobody),
    // where the next search starts, last select, cycles held, timeout flag.
    int m_owner;
    int m_ptr;
    int m_sel;
    int m_held;
    bit m_to;

    dec_rr_arbiter #(
        .MAX_HOLD(TB_MAX_HOLD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req(req),
        .done(done),
        .E(E),
        .S1(S1),
        .S0(S0),
        .gnt(gnt),
        .busy(busy),
        .timeout(timeout)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance the model on each rising edge from the inputs held stable
    // since the preceding falling edge.
    always @(posedge clk) begin
        if (rst) begin
            m_owner = -1;
            m_ptr   = 0;
            m_sel   = 0;
            m_held  = 0;
            m_to    = 1'b0;
        end else if (m_owner < 0) begin
            m_to = 1'b0;
            for (int k = 0; k < 4; k++) begin
                if (m_owner < 0 && req[(m_ptr + k) % 4]) begin
                    m_owner = (m_ptr + k) % 4;
                end
            end
            if (m_owner >= 0) begin
                m_sel  = m_owner;
                m_ptr  = (m_owner + 1) % 4;
                m_held = 1;
            end
        end else begin
            m_to = 1'b0;
            if (done || !req[m_owner]) begin
                m_owner = -1;
            end else if (TO_EN && m_held >= TB_MAX_HOLD) begin
                m_owner = -1;
                m_to    = 1'b1;
            end else begin
                m_held = m_held + 1;
            end
        end
    end

    // Compare every DUT output with the model on each falling edge.
    always @(negedge clk) begin
        logic [3:0] exp_gnt;
        logic       exp_e;
        if (chk_en) begin
            exp_e   = (m_owner >= 0);
            exp_gnt = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
            checks++;
            if (E !== exp_e || gnt !== exp_gnt || {S1, S0} !== 2'(m_sel) ||
                busy !== exp_e || timeout !== m_to) begin
                errors++;
                $display("[TB] FAIL model t=%0t got E=%b S=%b%b gnt=%b busy=%b to=%b want E=%b S=%0d gnt=%b busy=%b to=%b",
                         $time, E, S1, S0, gnt, busy, timeout,
                         exp_e, m_sel, exp_gnt, exp_e, m_to);
            end
        end
    end

    // Drive one cycle of inputs at the falling edge, then wait until just
    // after the following rising edge so outputs reflect that edge.
    task automatic applyStimulus(input logic [3:0] r, input logic d, input logic rs);
        @(negedge clk);
        req  = r;
        done = d;
        rst  = rs;
        @(posedge clk);
        #1;
    endtask

    // Compare outputs against hand-computed literal values.
    task automatic checkOutput(input string name, input logic e, input logic [1:0] sel,
                               input logic [3:0] g, input logic to);
        checks++;
        if (E !== e || {S1, S0} !== sel || gnt !== g || busy !== e || timeout !== to) begin
            errors++;
            $display("[TB] FAIL %s got E=%b S=%b%b gnt=%b busy=%b to=%b want E=%b S=%b gnt=%b busy=%b to=%b",
                     name, E, S1, S0, gnt, busy, timeout, e, sel, g, e, to);
        end
    endtask

    initial begin
        logic [3:0] rot_gnt  [8];
        logic [1:0] rot_sel  [8];
        logic       rot_done [8];
        logic [3:0] rr;
        int         high_cnt;

        checks = 0;
        errors = 0;
        chk_en = 1'b0;
        rst    = 1'b1;
        req    = 4'b0000;
        done   = 1'b0;

        rot_gnt  = '{4'b0000, 4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001};
        rot_sel  = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd3, 2'd3, 2'd0};
        rot_done = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        // Reset held two cycles with all requests high.
        applyStimulus(4'b1111, 1'b0, 1'b1);
        chk_en = 1'b1;
        applyStimulus(4'b1111, 1'b0, 1'b1);
        checkOutput("reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        applyStimulus(4'b1111, 1'b0, 1'b0);
        checkOutput("first_grant", 1'b1, 2'd0, 4'b0001, 1'b0);

        // Rotation 0,1,2,3,0 with done on each busy cycle.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(4'b1111, rot_done[i], 1'b0);
            checkOutput($sformatf("rotation_%0d", i), rot_gnt[i] != 4'b0000,
                        rot_sel[i], rot_gnt[i], 1'b0);
        end

        // Owner drop: owner 0 drops, grant 2, then 2 drops in favour of 0.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        checkOutput("drop_release", 1'b0, 2'd0, 4'b0000, 1'b0);
        applyStimulus(4'b0100, 1'b0, 1'b0);
        checkOutput("drop_grant2", 1'b1, 2'd2, 4'b0100, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("drop_gap", 1'b0, 2'd2, 4'b0000, 1'b0);
        applyStimulus(4'b0001, 1'b0, 1'b0);
        checkOutput("drop_grant0", 1'b1, 2'd0, 4'b0001, 1'b0);

        // Pointer wrap: winner 3 leaves ptr at 0, so 1010 grants 1.
        applyStimulus(4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("wrap_grant3", 1'b1, 2'd3, 4'b1000, 1'b0);
        applyStimulus(4'b1010, 1'b1, 1'b0);
        checkOutput("wrap_release", 1'b0, 2'd3, 4'b0000, 1'b0);
        applyStimulus(4'b1010, 1'b0, 1'b0);
        checkOutput("wrap_grant1", 1'b1, 2'd1, 4'b0010, 1'b0);

        // Reset while requester 3 owns the decoder.
        applyStimulus(4'b1000, 1'b0, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b0);
        checkOutput("midrst_grant3", 1'b1, 2'd3, 4'b1000, 1'b0);
        applyStimulus(4'b1000, 1'b0, 1'b1);
        checkOutput("midrst_reset", 1'b0, 2'd0, 4'b0000, 1'b0);
        applyStimulus(4'b1001, 1'b0, 1'b0);
        checkOutput("midrst_grant0", 1'b1, 2'd0, 4'b0001, 1'b0);

        // Long hold of requester 1 without done.
        applyStimulus(4'b0000, 1'b0, 1'b0);
        applyStimulus(4'b0010, 1'b0, 1'b0);
        checkOutput("hold_grant", 1'b1, 2'd1, 4'b0010, 1'b0);
        if (TO_EN) begin
            for (int i = 0; i < TB_MAX_HOLD - 1; i++) begin
                applyStimulus(4'b0010, 1'b0, 1'b0);
                checkOutput($sformatf("hold_high_%0d", i), 1'b1, 2'd1, 4'b0010, 1'b0);
            end
            applyStimulus(4'b0010, 1'b0, 1'b0);
            checkOutput("timeout_pulse", 1'b0, 2'd1, 4'b0000, 1'b1);
            applyStimulus(4'b0010, 1'b0, 1'b0);
            checkOutput("timeout_regrant", 1'b1, 2'd1, 4'b0010, 1'b0);
        end else begin
            high_cnt = 1;
            for (int i = 0; i < 110; i++) begin
                applyStimulus(4'b0010, 1'b0, 1'b0);
                if (E === 1'b1 && timeout === 1'b0) high_cnt++;
            end
            checks++;
            if (high_cnt != 111) begin
                errors++;
                $display("[TB] FAIL no_timeout got %0d high cycles want 111", high_cnt);
            end
        end

        // Randomized traffic checked by the model.
        rr = 4'b0000;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 2) == 0) rr = 4'($urandom_range(0, 15));
            applyStimulus(rr, $urandom_range(0, 3) == 0, $urandom_range(0, 99) == 0);
        end

        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
